// File: rtl/matrix_stream_loader.sv
// Collects a row-major element stream into a packed N x N matrix word and presents it
// downstream over valid/ready; one output register lets the next matrix fill behind it.
module matrix_stream_loader #(
  parameter  int ELEM_W = 4,
  parameter  int N      = 3,
  localparam int MAT_W  = ELEM_W * N * N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_first,
  output logic              mat_valid,
  input  logic              mat_ready,
  output logic [MAT_W-1:0]  mat_data,
  output logic              frame_err
);

  // state | meaning
  // IDLE  | no partial matrix held, count == 0
  // FILL  | count elements (1..N*N-1) of the current matrix captured
  localparam int NE    = N * N;
  localparam int CNT_W = $clog2(NE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NE - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  count, count_next;
  logic [MAT_W-1:0]  fill, fill_next;
  logic [MAT_W-1:0]  mat_data_next;
  logic              mat_valid_next;
  logic              frame_err_next;
  logic [MAT_W-1:0]  word_ins;
  logic [MAT_W-1:0]  word_fresh;
  logic              accept;

  assign in_ready = !(count == LAST && mat_valid && !mat_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_next     = state;
    count_next     = count;
    fill_next      = fill;
    mat_data_next  = mat_data;
    mat_valid_next = mat_valid && !mat_ready;
    frame_err_next = 1'b0;
    word_ins       = fill;
    word_ins[MAT_W-1-int'(count)*ELEM_W -: ELEM_W] = in_data;
    word_fresh     = '0;
    word_fresh[MAT_W-1 -: ELEM_W] = in_data;

    if (accept) begin
      unique case (state)
        IDLE: begin
          fill_next  = word_fresh;
          count_next = CNT_W'(1);
          state_next = FILL;
        end
        FILL: begin
          // in_first mid-matrix restarts the frame even on what would be the last slot
          if (in_first) begin
            fill_next      = word_fresh;
            count_next     = CNT_W'(1);
            frame_err_next = 1'b1;
          end else if (count == LAST) begin
            mat_data_next  = word_ins;
            mat_valid_next = 1'b1;
            fill_next      = '0;
            count_next     = '0;
            state_next     = IDLE;
          end else begin
            fill_next  = word_ins;
            count_next = count + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      fill      <= '0;
      mat_data  <= '0;
      mat_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      fill      <= fill_next;
      mat_data  <= mat_data_next;
      mat_valid <= mat_valid_next;
      frame_err <= frame_err_next;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: fill, stall, resync, reset and a
// scoreboarded run of 50 matrices with random gaps and back-pressure.
module tb_matrix_stream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_first;
  logic        mat_valid;
  logic        mat_ready;
  logic [35:0] mat_data;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  matrix_stream_loader dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first(in_first),
    .mat_valid(mat_valid), .mat_ready(mat_ready), .mat_data(mat_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one element and return at posedge+1 after its handshake.
  task automatic send(input logic [3:0] d, input logic f);
    int   n;
    logic ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("send_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    in_first = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_first = 1'b0; mat_ready = 1'b0;
    #3;
    check("rst_mat_valid", mat_valid, 0);
    check("rst_mat_data", mat_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // single matrix, free-running consumer
    mat_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      send(4'(i), i == 1);
      if (i < 9) check("t1_no_early_valid", mat_valid, 0);
    end
    check("t1_valid", mat_valid, 1);
    check("t1_data", mat_data, 36'h123456789);
    idle(1);
    check("t1_valid_one_cycle", mat_valid, 0);

    // two matrices against a stalled consumer, then completion coincident with consume
    mat_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(4'(i), i == 1);
    check("t2_first_valid", mat_valid, 1);
    check("t2_first_data", mat_data, 36'h123456789);
    for (int i = 9; i >= 2; i--) send(4'(i), i == 9);
    check("t2_hold_data", mat_data, 36'h123456789);
    in_valid = 1'b1; in_data = 4'd1; in_first = 1'b0;
    @(negedge clk);
    check("t2_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("t2_still_valid", mat_valid, 1);
    check("t2_still_data", mat_data, 36'h123456789);
    mat_ready = 1'b1;
    @(negedge clk);
    check("t2_in_ready_high", in_ready, 1);
    @(posedge clk); #1;
    check("t6_valid_no_bubble", mat_valid, 1);
    check("t6_new_data", mat_data, 36'h987654321);
    idle(1);
    check("t2_drained", mat_valid, 0);

    // resync on in_first mid-matrix
    for (int i = 1; i <= 5; i++) send(4'(i), i == 1);
    check("t3_no_err_before", frame_err, 0);
    send(4'hA, 1'b1);
    check("t3_err_pulse", frame_err, 1);
    send(4'hB, 1'b0);
    check("t3_err_once", frame_err, 0);
    send(4'hC, 1'b0); send(4'hD, 1'b0); send(4'hE, 1'b0); send(4'hF, 1'b0);
    send(4'h0, 1'b0); send(4'h1, 1'b0);
    check("t3_no_valid_yet", mat_valid, 0);
    send(4'h2, 1'b0);
    check("t3_valid", mat_valid, 1);
    check("t3_data", mat_data, 36'hABCDEF012);
    check("t3_err_quiet", frame_err, 0);
    idle(2);

    // scoreboarded random run
    fork
      begin
        for (int m = 0; m < 50; m++) begin
          logic [35:0] w;
          logic [3:0]  d;
          w = '0;
          for (int k = 0; k < 9; k++) begin
            d = 4'($urandom);
            w = {w[31:0], d};
            send(d, k == 0);
            if (k == 8) exp_q.push_back(w);
            if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
          end
        end
        in_valid = 1'b0;
      end
      begin
        int          got;
        int          cyc;
        logic        stall;
        logic [35:0] held;
        got = 0; cyc = 0; stall = 1'b0; held = '0;
        while (got < 50 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (stall) begin
            check("t4_stall_valid", mat_valid, 1);
            check("t4_stall_data", mat_data, held);
          end
          if (mat_valid && mat_ready) begin
            if (exp_q.size() == 0) check("t4_sb_empty", exp_q.size(), 1);
            else check("t4_word", mat_data, exp_q.pop_front());
            got++;
          end
          stall = mat_valid && !mat_ready;
          held  = mat_data;
          @(posedge clk); #1;
          mat_ready = 1'($urandom_range(1));
        end
        check("t4_word_count", got, 50);
      end
    join
    mat_ready = 1'b1;
    idle(3);
    check("t4_drained", mat_valid, 0);

    // reset mid-fill with a pending word
    mat_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(4'(i), i == 1);
    check("t5_pending", mat_valid, 1);
    for (int i = 0; i < 4; i++) send(4'h5, i == 0);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("t5_rst_valid", mat_valid, 0);
    check("t5_rst_data", mat_data, 0);
    check("t5_rst_err", frame_err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mat_ready = 1'b1;
    send(4'h2, 1'b0); send(4'h4, 1'b0); send(4'h6, 1'b0);
    send(4'h8, 1'b0); send(4'hA, 1'b0); send(4'hC, 1'b0);
    send(4'hE, 1'b0); send(4'h1, 1'b0);
    check("t5_no_stale", mat_valid, 0);
    send(4'h3, 1'b0);
    check("t5_valid", mat_valid, 1);
    check("t5_data", mat_data, 36'h2468ACE13);
    idle(1);
    check("t5_drained", mat_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
